// File: rtl/lottery_pkg.sv
// Shared definitions for the lottery checker: state codes, drawn number,
// prize classes, display codes and the prize rule.
package lottery_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_FULL   = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  localparam int NUM_DIGITS = 5;

  localparam logic [3:0] DRAWN_W1 = 4'd4;
  localparam logic [3:0] DRAWN_W2 = 4'd7;
  localparam logic [3:0] DRAWN_W3 = 4'd0;
  localparam logic [3:0] DRAWN_W4 = 4'd1;
  localparam logic [3:0] DRAWN_W5 = 4'd9;

  localparam logic [1:0] PRIZE_NONE   = 2'd0;
  localparam logic [1:0] PRIZE_FIRST  = 2'd1;
  localparam logic [1:0] PRIZE_SECOND = 2'd2;

  // Display codes beyond the BCD range understood by hex7seg.
  localparam logic [3:0] CODE_P     = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  // Segment patterns, a..g from left to right, active-low.
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_P     = 7'b0011000;

  // match[0] is digit 1; the run is measured only over digits 1..4.
  function automatic logic [1:0] prize_class(input logic [4:0] match);
    logic run4, run3, run2;
    run4 = &match[3:0];
    run3 = (match[0] & match[1] & match[2]) | (match[1] & match[2] & match[3]);
    run2 = (match[0] & match[1]) | (match[1] & match[2]) | (match[2] & match[3]);
    if (run4)                 prize_class = PRIZE_FIRST;
    else if (run3)            prize_class = match[4] ? PRIZE_FIRST : PRIZE_NONE;
    else if (run2 && match[4]) prize_class = PRIZE_SECOND;
    else                      prize_class = PRIZE_NONE;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Display code to 7-segment decoder: BCD 0-9, 'P', anything else blank.
module hex7seg
  import lottery_pkg::*;
(
  input  logic [3:0] code,
  output logic [0:6] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      CODE_P:  seg = SEG_P;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/lottery_checker_top.sv
// Five-digit lottery ticket checker: digit entry FSM, prize evaluation,
// win counters and 7-segment display drive.
module lottery_checker_top
  import lottery_pkg::*;
#(
  parameter logic [3:0] W1 = DRAWN_W1,
  parameter logic [3:0] W2 = DRAWN_W2,
  parameter logic [3:0] W3 = DRAWN_W3,
  parameter logic [3:0] W4 = DRAWN_W4,
  parameter logic [3:0] W5 = DRAWN_W5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] num,
  input  logic       insere,
  input  logic       fim,
  input  logic       fim_jogo,
  output logic [0:6] hex0,
  output logic [0:6] hex1,
  output logic [0:6] hex2,
  output logic [0:6] hex3,
  output logic [1:0] ledp1,
  output logic [1:0] ledp2,
  output logic       led15,
  output logic [3:0] state,
  output logic [3:0] sled,
  output logic [3:0] gled
);

  state_t     state_q, state_d;
  logic [3:0] digit_q [0:NUM_DIGITS-1];
  logic [3:0] sled_q, gled_q;
  logic [1:0] ledp1_q, ledp2_q;

  logic       store, clear, eval, done;
  logic       num_valid;
  logic [4:0] match;
  logic [1:0] prize;
  logic [3:0] code [0:3];

  assign num_valid = (num <= 4'd9);

  always_comb begin
    match[0] = (digit_q[0] == W1);
    match[1] = (digit_q[1] == W2);
    match[2] = (digit_q[2] == W3);
    match[3] = (digit_q[3] == W4);
    match[4] = (digit_q[4] == W5);
    prize    = prize_class(match);
  end

  // Next state; fim_jogo outranks fim, which outranks insere.
  always_comb begin
    state_d = state_q;
    store   = 1'b0;
    clear   = 1'b0;
    eval    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fim_jogo) begin
          clear = 1'b1;
        end else if (insere && num_valid) begin
          store   = 1'b1;
          state_d = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (insere && num_valid) begin
          store = 1'b1;
          if (sled_q == 4'(NUM_DIGITS - 1)) state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (fim_jogo) begin
          clear   = 1'b1;
          state_d = ST_IDLE;
        end else if (fim) begin
          eval    = 1'b1;
          state_d = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (fim_jogo) begin
          clear   = 1'b1;
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 4'd0;
      sled_q  <= 4'd0;
      gled_q  <= 4'd0;
      ledp1_q <= PRIZE_NONE;
      ledp2_q <= 2'd0;
    end else begin
      state_q <= state_d;
      if (store) begin
        for (int i = 0; i < NUM_DIGITS; i++)
          if (sled_q == 4'(i)) digit_q[i] <= num;
        sled_q <= sled_q + 4'd1;
      end
      if (clear) begin
        for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 4'd0;
        sled_q <= 4'd0;
      end
      if (done) gled_q <= gled_q + 4'd1;
      if (eval) begin
        ledp1_q <= prize;
        if (prize != PRIZE_NONE && ledp2_q != 2'd3) ledp2_q <= ledp2_q + 2'd1;
      end
    end
  end

  // code[0] drives hex0 (rightmost, newest digit); code[k] shows digit sled-k.
  always_comb begin
    for (int k = 0; k < 4; k++) code[k] = CODE_BLANK;
    case (state_q)
      ST_ENTRY, ST_FULL: begin
        for (int k = 0; k < 4; k++)
          for (int i = 0; i < NUM_DIGITS; i++)
            if (int'(sled_q) == i + 1 + k) code[k] = digit_q[i];
      end
      ST_RESULT: begin
        code[3] = CODE_P;
        code[0] = {2'b00, ledp1_q};
      end
      default: ;
    endcase
  end

  hex7seg u_hex0 (.code(code[0]), .seg(hex0));
  hex7seg u_hex1 (.code(code[1]), .seg(hex1));
  hex7seg u_hex2 (.code(code[2]), .seg(hex2));
  hex7seg u_hex3 (.code(code[3]), .seg(hex3));

  assign state = {2'b00, state_q};
  assign sled  = sled_q;
  assign gled  = gled_q;
  assign ledp1 = ledp1_q;
  assign ledp2 = ledp2_q;
  assign led15 = (state_q == ST_RESULT);

endmodule

// File: tb/tb_lottery_checker_top.sv
// Bench for lottery_checker_top: directed games plus randomized games,
// compared every cycle against a transaction-level model of the checker.
module tb_lottery_checker_top;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] num;
  logic       insere, fim, fim_jogo;
  logic [0:6] hex0, hex1, hex2, hex3;
  logic [1:0] ledp1, ledp2;
  logic       led15;
  logic [3:0] state, sled, gled;

  lottery_checker_top dut (
    .clk(clk), .reset(reset), .num(num), .insere(insere), .fim(fim),
    .fim_jogo(fim_jogo), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .ledp1(ledp1), .ledp2(ledp2), .led15(led15), .state(state), .sled(sled),
    .gled(gled)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: abstract game state.
  int w [0:4] = '{4, 7, 0, 1, 9};
  int m_state, m_gled, m_p1, m_p2;
  int m_dig [$];

  // Lit segments per symbol; index 10 is 'P'.
  string lit [0:10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                        "acdefg", "abc", "abcdefg", "abcdfg", "abefg"};

  function automatic logic [0:6] seg_of(input int sym);
    logic [0:6] r;
    string s;
    r = 7'b1111111;
    if (sym >= 0 && sym <= 10) begin
      s = lit[sym];
      for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
    end
    return r;
  endfunction

  function automatic int model_prize();
    int run, best, hits;
    bit m [0:4];
    run = 0; best = 0; hits = 0;
    for (int i = 0; i < 5; i++) begin
      m[i] = (m_dig[i] == w[i]);
      if (m[i]) hits++;
    end
    for (int i = 0; i < 4; i++) begin
      run = m[i] ? run + 1 : 0;
      if (run > best) best = run;
    end
    if (hits == 5) return 1;
    if (best == 4 || (best == 3 && m[4])) return 1;
    if (best == 2 && m[4]) return 2;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic check_all();
    int sym [0:3];
    for (int k = 0; k < 4; k++) sym[k] = -1;
    if (m_state == 3) begin
      sym[3] = 10;
      sym[0] = m_p1;
    end else if (m_state != 0) begin
      for (int k = 0; k < 4; k++)
        if (k < m_dig.size()) sym[k] = m_dig[m_dig.size() - 1 - k];
    end
    chk("state", 7'(state), 7'(m_state));
    chk("sled", 7'(sled), 7'(m_dig.size()));
    chk("gled", 7'(gled), 7'(m_gled));
    chk("ledp1", 7'(ledp1), 7'(m_p1));
    chk("ledp2", 7'(ledp2), 7'(m_p2));
    chk("led15", 7'(led15), 7'(m_state == 3));
    chk("hex0", hex0, seg_of(sym[0]));
    chk("hex1", hex1, seg_of(sym[1]));
    chk("hex2", hex2, seg_of(sym[2]));
    chk("hex3", hex3, seg_of(sym[3]));
  endtask

  // One clock with the given inputs, then the model follows the game rules.
  task automatic step(input logic ins, input int n, input logic f, input logic fj);
    int p;
    insere = ins; num = 4'(n); fim = f; fim_jogo = fj;
    @(posedge clk); #1;
    case (m_state)
      0: if (fj) m_dig.delete();
         else if (ins && n <= 9) begin m_dig.push_back(n); m_state = 1; end
      1: if (ins && n <= 9) begin
           m_dig.push_back(n);
           if (m_dig.size() == 5) m_state = 2;
         end
      2: if (fj) begin m_dig.delete(); m_state = 0; end
         else if (f) begin
           p = model_prize();
           m_p1 = p;
           if (p != 0 && m_p2 < 3) m_p2++;
           m_state = 3;
         end
      default: if (fj) begin m_dig.delete(); m_gled = (m_gled + 1) % 16; m_state = 0; end
    endcase
    check_all();
  endtask

  task automatic play(input int d [0:4]);
    for (int i = 0; i < 5; i++) step(1'b1, d[i], 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic model_reset();
    m_state = 0; m_gled = 0; m_p1 = 0; m_p2 = 0;
    m_dig.delete();
  endtask

  initial begin
    int r, d, guard;
    reset = 1'b1; num = 4'd0; insere = 1'b0; fim = 1'b0; fim_jogo = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    step(1'b0, 0, 1'b1, 1'b0);               // fim in IDLE does nothing
    play('{4, 7, 0, 1, 0});                  // run of four: first
    chk("game1_gled", 7'(gled), 7'd1);
    play('{6, 7, 0, 3, 9});                  // run of two plus fifth: second
    chk("game2_ledp2", 7'(ledp2), 7'd2);
    play('{4, 7, 0, 2, 9});                  // run of three plus fifth: first
    play('{2, 3, 1, 1, 9});
    play('{4, 9, 2, 1, 9});                  // scattered matches: none
    chk("game5_gled", 7'(gled), 7'd5);
    chk("game5_ledp2", 7'(ledp2), 7'd3);

    // Invalid digits, pauses, extra insere in FULL, fim_jogo beating fim.
    step(1'b1, 4, 1'b0, 1'b0);
    step(1'b1, 12, 1'b0, 1'b0);
    step(1'b0, 7, 1'b0, 1'b0);
    step(1'b1, 7, 1'b1, 1'b0);
    step(1'b1, 15, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0);
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b1, 9, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b0);
    step(1'b1, 0, 1'b1, 1'b1);

    // Randomized games, some abandoned from FULL.
    for (int g = 0; g < 20; g++) begin
      guard = 0;
      while (m_dig.size() < 5 && guard < 60) begin
        guard++;
        r = $urandom_range(0, 7);
        if (r == 0 || (r == 1 && m_dig.size() == 0))
          step(1'b0, $urandom_range(0, 15), 1'b0, 1'b0);
        else if (r == 1)
          step(1'b1, $urandom_range(10, 15), 1'b0, 1'b0);
        else begin
          d = ($urandom_range(0, 2) != 0) ? w[m_dig.size()] : $urandom_range(0, 9);
          step(1'b1, d, 1'b0, 1'b0);
        end
      end
      step(1'b1, $urandom_range(0, 9), 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        step(1'b0, 0, 1'b0, 1'b1);
      end else begin
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b1, 3, 1'b1, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1);
      end
    end

    // Asynchronous reset in the middle of an entry.
    step(1'b1, 4, 1'b0, 1'b0);
    step(1'b1, 7, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0);
    chk("pre_reset_sled", 7'(sled), 7'd3);
    insere = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 reset = 1'b0;
    step(1'b1, 8, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
